// File: rtl/lut_search_pkg.sv
// Shared constants, FSM state type and table contents for the reverse-lookup search.
// The table is the single source of truth for both the ROM and anyone decoding results.
package lut_search_pkg;

  localparam int IDX_W       = 6;
  localparam int VAL_W       = 8;
  localparam int CNT_W       = 4;
  localparam int TABLE_DEPTH = 64;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  // Entries past the populated range read as zero; the search bounds itself by NUM_ENTRIES.
  localparam logic [VAL_W-1:0] LUT_TABLE [TABLE_DEPTH] = '{
    0: 8'd3,   1: 8'd71,  2: 8'd18,  3: 8'd115,
    4: 8'd35,  5: 8'd31,  6: 8'd89,  7: 8'd31,
    8: 8'd17,  9: 8'd5,   10: 8'd8,  11: 8'd14,
    12: 8'd2,  13: 8'd5,
    default: 8'd0
  };

endpackage

// File: rtl/lut_table_rom.sv
// Combinational 64 x 8 constant table, addressed by the scan counter.
module lut_table_rom
  import lut_search_pkg::*;
(
  input  logic [IDX_W-1:0] addr,
  output logic [VAL_W-1:0] data
);

  assign data = LUT_TABLE[addr];

endmodule

// File: rtl/lut_reverse_search.sv
// Sequential reverse lookup: scans the table one entry per cycle for a registered key.
// Define LUT_SEARCH_COUNT_EN to scan the full table and report the number of matches.
module lut_reverse_search
  import lut_search_pkg::*;
#(
  parameter int NUM_ENTRIES = 14
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [VAL_W-1:0] key,
  output logic             busy,
  output logic             done,
  output logic             found,
  output logic [IDX_W-1:0] index
`ifdef LUT_SEARCH_COUNT_EN
  ,
  output logic [CNT_W-1:0] match_count
`endif
);

  state_t           state;
  state_t           state_nxt;
  logic [VAL_W-1:0] key_q;
  logic [IDX_W-1:0] scan_idx;
  logic [VAL_W-1:0] rom_data;
  logic             hit;
  logic             last_entry;
  logic             scan_end;

  lut_table_rom u_rom (
    .addr (scan_idx),
    .data (rom_data)
  );

  assign hit        = (state == SCAN) && (int'(scan_idx) < NUM_ENTRIES) && (rom_data == key_q);
  assign last_entry = (int'(scan_idx) == NUM_ENTRIES - 1);

`ifdef LUT_SEARCH_COUNT_EN
  assign scan_end = last_entry;
`else
  assign scan_end = last_entry || hit;
`endif

  assign busy = (state != IDLE);
  assign done = (state == DONE);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    // NOTE: default first so every path assigns state_nxt and no latch is inferred.
    state_nxt = state;
    unique case (state)
      IDLE:    if (start) state_nxt = SCAN;
      SCAN:    if (scan_end) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

`ifdef LUT_SEARCH_COUNT_EN
  logic             hit_seen;
  logic [IDX_W-1:0] first_idx;
  logic [CNT_W-1:0] hit_cnt;
`endif

  // NOTE: non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      key_q       <= '0;
      scan_idx    <= '0;
      found       <= 1'b0;
      index       <= '0;
`ifdef LUT_SEARCH_COUNT_EN
      hit_seen    <= 1'b0;
      first_idx   <= '0;
      hit_cnt     <= '0;
      match_count <= '0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            key_q     <= key;
            scan_idx  <= '0;
`ifdef LUT_SEARCH_COUNT_EN
            hit_seen  <= 1'b0;
            first_idx <= '0;
            hit_cnt   <= '0;
`endif
          end
        end
        SCAN: begin
          scan_idx <= scan_idx + 1'b1;
`ifdef LUT_SEARCH_COUNT_EN
          if (hit) begin
            hit_cnt <= hit_cnt + 1'b1;
            if (!hit_seen) begin
              hit_seen  <= 1'b1;
              first_idx <= scan_idx;
            end
          end
          // The final entry's own hit is folded in here since the accumulators lag a cycle.
          if (scan_end) begin
            found       <= hit_seen || hit;
            index       <= hit_seen ? first_idx : (hit ? scan_idx : '0);
            match_count <= hit_cnt + CNT_W'(hit);
          end
`else
          if (scan_end) begin
            found <= hit;
            index <= hit ? scan_idx : '0;
          end
`endif
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_lut_reverse_search.sv
// Directed self-checking bench for lut_reverse_search (default and LUT_SEARCH_COUNT_EN builds).
module tb_lut_reverse_search;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [7:0] key;
  logic       busy;
  logic       done;
  logic       found;
  logic [5:0] index;
`ifdef LUT_SEARCH_COUNT_EN
  logic [3:0] match_count;
`endif

  int errors = 0;
  int checks = 0;

  lut_reverse_search #(.NUM_ENTRIES(14)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .key   (key),
    .busy  (busy),
    .done  (done),
    .found (found),
    .index (index)
`ifdef LUT_SEARCH_COUNT_EN
    ,
    .match_count (match_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // Waits for done; cyc is the cycle number (relative to the start cycle) already reached.
  task automatic wait_done(input int cyc, output int lat);
    lat = cyc;
    while (done !== 1'b1 && lat < 100) begin
      tick();
      lat++;
    end
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL done_timeout observed=0 expected=1");
    end
  endtask

  // Pulses start for one cycle, then scrambles key to prove it was registered.
  task automatic launch(input logic [7:0] k);
    start = 1'b1;
    key   = k;
    tick();
    start = 1'b0;
    key   = ~k;
  endtask

  task automatic search(input string tag, input logic [7:0] k, input int exp_lat,
                        input logic exp_found, input logic [5:0] exp_index, input int exp_cnt);
    int lat;
    launch(k);
    wait_done(1, lat);
    check({tag, "_latency"}, lat, exp_lat);
    check({tag, "_found"}, found, exp_found);
    check({tag, "_index"}, index, exp_index);
`ifdef LUT_SEARCH_COUNT_EN
    check({tag, "_count"}, match_count, exp_cnt);
`else
    if (exp_cnt < 0) $display("unexpected count argument");
`endif
    tick();
    check({tag, "_idle_after"}, {busy, done}, 2'b00);
  endtask

`ifdef LUT_SEARCH_COUNT_EN
  localparam bit CNT_MODE = 1'b1;
`else
  localparam bit CNT_MODE = 1'b0;
`endif

  initial begin
    int lat;
    int pulses;
    reset = 1'b1;
    start = 1'b0;
    key   = 8'd0;
    repeat (3) tick();
    check("reset_busy", busy, 1'b0);
    check("reset_done", done, 1'b0);
    check("reset_found", found, 1'b0);
    check("reset_index", index, 6'd0);
`ifdef LUT_SEARCH_COUNT_EN
    check("reset_count", match_count, 4'd0);
`endif
    reset = 1'b0;
    tick();

    // First entry, duplicates, miss, and an entry past index 0 with a late hit.
    search("key3",   8'd3,   CNT_MODE ? 15 : 2,  1'b1, 6'd0,  1);
    search("key5",   8'd5,   CNT_MODE ? 15 : 11, 1'b1, 6'd9,  2);
    search("key200", 8'd200, 15,                 1'b0, 6'd0,  0);
    search("key31",  8'd31,  CNT_MODE ? 15 : 7,  1'b1, 6'd5,  2);
    search("key0",   8'd0,   15,                 1'b0, 6'd0,  0);

    // Start while busy is ignored; results hold through IDLE; back-to-back start accepted.
    launch(8'd115);
    tick();
    start = 1'b1;
    key   = 8'd2;
    tick();
    start = 1'b0;
    check("ignore_busy", busy, 1'b1);
    wait_done(3, lat);
    check("ignore_latency", lat, CNT_MODE ? 15 : 5);
    check("ignore_found", found, 1'b1);
    check("ignore_index", index, 6'd3);
    tick();
    check("hold_found", found, 1'b1);
    check("hold_index", index, 6'd3);
    search("key2_b2b", 8'd2, CNT_MODE ? 15 : 14, 1'b1, 6'd12, 1);

    // Reset mid-scan discards the search; no done pulse follows.
    launch(8'd14);
    repeat (4) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("midreset_busy", busy, 1'b0);
    check("midreset_done", done, 1'b0);
    check("midreset_found", found, 1'b0);
    check("midreset_index", index, 6'd0);
`ifdef LUT_SEARCH_COUNT_EN
    check("midreset_count", match_count, 4'd0);
`endif
    pulses = 0;
    for (int i = 0; i < 16; i++) begin
      if (done === 1'b1 || busy === 1'b1) pulses++;
      tick();
    end
    check("midreset_quiet", pulses, 0);
    search("key14", 8'd14, CNT_MODE ? 15 : 13, 1'b1, 6'd11, 1);

    // Reset wins over a simultaneous start.
    reset = 1'b1;
    start = 1'b1;
    key   = 8'd71;
    tick();
    reset = 1'b0;
    start = 1'b0;
    check("reset_prio_busy", busy, 1'b0);
    tick();
    check("reset_prio_still_idle", busy, 1'b0);
    search("key71", 8'd71, CNT_MODE ? 15 : 3, 1'b1, 6'd1, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/lut_reverse_search.md
LUT_REVERSE_SEARCH -- requirements
Module: lut_reverse_search

Interface
REQ-001 SHALL have parameter: NUM_ENTRIES, 14, count of valid table entries scanned (indices 0..NUM_ENTRIES-1, max 64).
REQ-002 SHALL have one clock; reset is synchronous and active-high.
REQ-003 SHALL have ports:
  clk  input  1  rising-edge clock
  reset  input  1  synchronous active-high reset
  start  input  1  request pulse; key sampled when start=1 in IDLE
  key  input  8  value to locate in the table
  busy  output  1  high while a search is in progress (SCAN or DONE)
  done  output  1  one-cycle pulse, result valid
  found  output  1  key present in table; held until next accepted start
  index  output  6  matching table index; 0 when not found; held until next accepted start
  match_count  output  4  number of matching entries; only with LUT_SEARCH_COUNT_EN

Function
REQ-004 SHALL implement reverse lookup of the 6-bit-index -> 8-bit-value table: 0:3, 1:71, 2:18, 3:115, 4:35, 5:31, 6:89, 7:31, 8:17, 9:5, 10:8, 11:14, 12:2, 13:5.
REQ-005 SHALL use FSM states IDLE, SCAN, DONE; IDLE->SCAN on start; SCAN->DONE on match (early exit) or after index NUM_ENTRIES-1; DONE->IDLE unconditionally.
REQ-006 SHALL register key on the accepted start; later key changes have no effect on the search in progress.
REQ-007 SHALL examine exactly one entry per cycle, entry k in the (k+1)th cycle after the start cycle.
REQ-008 SHALL assert done in the cycle after the deciding SCAN cycle: match at entry k -> done k+2 cycles after start; miss -> done NUM_ENTRIES+1 cycles after start.
REQ-009 SHALL return the lowest matching index for duplicate values (31 -> 5, 5 -> 9).
REQ-010 SHALL update found/index in the same cycle done rises, and hold them until the next accepted start.
REQ-011 SHALL ignore start while busy=1; no queuing.
REQ-012 SHALL accept start in the cycle after done (IDLE) with no dead cycle beyond DONE.
REQ-013 SHALL treat entries at index >= NUM_ENTRIES as absent.

Reset
REQ-014 SHALL on reset, including mid-scan, force IDLE, busy=0, done=0, found=0, index=0, match_count=0, and discard the scan in progress.
REQ-015 SHALL give reset priority over a simultaneous start; that start is lost.

Configuration
REQ-016 SHALL, with LUT_SEARCH_COUNT_EN defined, disable early exit, scan all entries (done always NUM_ENTRIES+1 cycles after start), report lowest match index, and drive match_count with the total number of matches.
REQ-017 SHALL, without LUT_SEARCH_COUNT_EN, omit the match_count port and counter logic and use early exit per REQ-005.

Structure
REQ-018 SHALL place table contents (constant array of 64 x 8 bit, unused entries 0), the state enum, and the width constants in shared package lut_search_pkg.
REQ-019 SHALL use one sub-module, lut_table_rom (6-bit index in, 8-bit value out, combinational), indexed by the scan counter.

Verification
REQ-020 SHALL cover: key=3 start -> done 2 cycles later, found=1, index=0.
REQ-021 SHALL cover: key=5 -> found=1, index=9, done 11 cycles after start; with LUT_SEARCH_COUNT_EN: done 15 cycles after start, index=9, match_count=2.
REQ-022 SHALL cover: key=200 -> done 15 cycles after start, found=0, index=0 (match_count=0 when enabled).
REQ-023 SHALL cover: key=115 start, second start with key=2 at cycle 2 -> second ignored; result found=1, index=3; start at first IDLE cycle after done accepted.
REQ-024 SHALL cover: key=14 start, reset at cycle 5 -> next cycle IDLE, all outputs 0, no done pulse; new start key=14 -> index=11.
